// File: rtl/bcd_host_pkg.sv
// Shared definitions for the serial BCD ALU host endpoint: frame widths, header
// defaults, FSM state encoding and the BCD digit validity helper.
package bcd_host_pkg;

  localparam logic [7:0] HDR_REQ_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR_RSP_DEFAULT = 8'h96;

  localparam int HDR_W = 8;
  localparam int REQ_W = 41;
  localparam int RSP_W = 28;
  localparam int RES_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_rsp_hunter.sv
// Response hunter: shifts ser_in into a 28-bit window and flags a header match on
// the value the register is about to take, so the result is usable the same edge.
module bcd_rsp_hunter
  import bcd_host_pkg::*;
#(
  parameter logic [7:0] HDR_RSP = HDR_RSP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_ser_in,
  output logic             o_match,
  output logic [RES_W-1:0] o_result
);

  logic [RSP_W-1:0] r_hunt;
  logic [RSP_W-1:0] w_hunt_next;

  assign w_hunt_next = {r_hunt[RSP_W-2:0], i_ser_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hunt <= '0;
    end else if (i_clear) begin
      r_hunt <= '0;
    end else if (i_shift) begin
      r_hunt <= w_hunt_next;
    end
  end

  // Zero-filled window: the header's leading 1 can only reach the top after a full 28 bits.
  assign o_match  = i_shift && (w_hunt_next[RSP_W-1 -: HDR_W] == HDR_RSP);
  assign o_result = w_hunt_next[RES_W-1:0];

endmodule

// File: rtl/bcd_alu_host.sv
// Host endpoint for the serial BCD ALU link: sends one 41-bit request frame MSB
// first, then hunts for the 28-bit response. Optional operand check: BCD_CHECK_EN.
module bcd_alu_host
  import bcd_host_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [7:0]  HDR_REQ        = HDR_REQ_DEFAULT,
  parameter logic [7:0]  HDR_RSP        = HDR_RSP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             rsp_valid,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_timeout,
  output logic             req_err,
  output logic             busy
);

  localparam int             WCW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT_CYCLES);
  localparam logic [5:0]     BIT_LAST   = 6'(REQ_W - 1);

  state_t             r_state,       w_state_next;
  logic [REQ_W-1:0]   r_frame,       w_frame_next;
  logic [5:0]         r_bit_cnt,     w_bit_cnt_next;
  logic [WCW-1:0]     r_wait_cnt,    w_wait_cnt_next;
  logic               r_ser_out,     w_ser_out_next;
  logic               r_rsp_valid,   w_rsp_valid_next;
  logic               r_rsp_timeout, w_rsp_timeout_next;
  logic               r_req_err,     w_req_err_next;
  logic [RES_W-1:0]   r_rsp_result,  w_rsp_result_next;

  logic               w_accept;
  logic               w_bcd_bad;
  logic [REQ_W-1:0]   w_req_frame;
  logic               w_match;
  logic [RES_W-1:0]   w_hunt_result;

  assign req_ready   = (r_state == IDLE) && !r_req_err;
  assign busy        = (r_state == SEND) || (r_state == WAIT);
  assign w_accept    = req_valid && req_ready;
  assign w_req_frame = {HDR_REQ, req_op, req_a, req_b};

`ifdef BCD_CHECK_EN
  logic [7:0] w_nib_ok;
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_nib
    assign w_nib_ok[gi]     = bcd_digit_ok(req_a[4*gi +: 4]);
    assign w_nib_ok[gi + 4] = bcd_digit_ok(req_b[4*gi +: 4]);
  end
  assign w_bcd_bad = ~&w_nib_ok;
`else
  assign w_bcd_bad = 1'b0;
`endif

  bcd_rsp_hunter #(
    .HDR_RSP (HDR_RSP)
  ) u_hunter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (r_state != WAIT),
    .i_shift  (r_state == WAIT),
    .i_ser_in (ser_in),
    .o_match  (w_match),
    .o_result (w_hunt_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_frame       <= '0;
      r_bit_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_ser_out     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_req_err     <= 1'b0;
      r_rsp_result  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_frame       <= w_frame_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_ser_out     <= w_ser_out_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_timeout <= w_rsp_timeout_next;
      r_req_err     <= w_req_err_next;
      r_rsp_result  <= w_rsp_result_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_frame_next       = r_frame;
    w_bit_cnt_next     = r_bit_cnt;
    w_wait_cnt_next    = r_wait_cnt;
    w_ser_out_next     = 1'b0;
    w_rsp_valid_next   = 1'b0;
    w_rsp_timeout_next = 1'b0;
    w_req_err_next     = 1'b0;
    w_rsp_result_next  = r_rsp_result;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_bcd_bad) begin
            w_req_err_next = 1'b1;
          end else begin
            // Bit 40 goes straight out so the line is driven the cycle after accept.
            w_frame_next   = w_req_frame;
            w_bit_cnt_next = '0;
            w_ser_out_next = w_req_frame[REQ_W-1];
            w_state_next   = SEND;
          end
        end
      end

      SEND: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_wait_cnt_next = '0;
          w_state_next    = WAIT;
        end else begin
          w_ser_out_next = r_frame[REQ_W-2];
          w_frame_next   = {r_frame[REQ_W-2:0], 1'b0};
          w_bit_cnt_next = r_bit_cnt + 6'd1;
        end
      end

      WAIT: begin
        w_wait_cnt_next = r_wait_cnt + WCW'(1);
        if (w_match) begin
          w_rsp_result_next = w_hunt_result;
          w_rsp_valid_next  = 1'b1;
          w_state_next      = IDLE;
        end else if (w_wait_cnt_next == WAIT_LIMIT) begin
          w_rsp_timeout_next = 1'b1;
          w_state_next       = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign ser_out     = r_ser_out;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_result  = r_rsp_result;
  assign req_err     = r_req_err;

endmodule

// File: tb/tb_bcd_alu_host.sv
// Self-checking bench for bcd_alu_host with a loopback BCD ALU responder and an
// expected-result queue; checks the operand-check path when BCD_CHECK_EN is defined.
module tb_bcd_alu_host;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        ser_out;
  logic        ser_in;
  logic        rsp_valid;
  logic [19:0] rsp_result;
  logic        rsp_timeout;
  logic        req_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] exp_q[$];

  bit          rsp_en = 1'b1;
  int          frames_seen = 0;
  logic [40:0] last_frame = '0;

  bcd_alu_host #(
    .TIMEOUT_CYCLES (256),
    .HDR_REQ        (8'hA5),
    .HDR_RSP        (8'h96)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .ser_out     (ser_out),
    .ser_in      (ser_in),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_timeout (rsp_timeout),
    .req_err     (req_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] x);
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [19:0] int2bcd(input int v_in);
    logic [19:0] r = '0;
    int v = v_in;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] alu_model(input logic [40:0] f);
    int a = bcd2int(f[31:16]);
    int b = bcd2int(f[15:0]);
    int r = f[32] ? (a - b + 100000) % 100000 : a + b;
    return int2bcd(r);
  endfunction

  // Loopback responder: captures the frame, waits 5 cycles after its last bit, replies.
  initial begin : responder
    int          rstate = 0;
    int          cnt = 0;
    logic [40:0] cap = '0;
    logic [27:0] rsp = '0;
    ser_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rstate = 0;
        ser_in = 1'b0;
      end else begin
        case (rstate)
          0: if (rsp_en && ser_out) begin
               cap = 41'd1; cnt = 1; rstate = 1;
             end
          1: begin
               cap = {cap[39:0], ser_out};
               cnt++;
               if (cnt == 41) begin
                 last_frame = cap;
                 frames_seen++;
                 rsp = {8'h96, alu_model(cap)};
                 cnt = 0; rstate = 2;
               end
             end
          2: begin
               cnt++;
               if (cnt == 5) begin
                 ser_in = rsp[27]; cnt = 1; rstate = 3;
               end
             end
          default: begin
               if (cnt == 28) begin
                 ser_in = 1'b0; rstate = 0;
               end else begin
                 ser_in = rsp[27 - cnt]; cnt++;
               end
             end
        endcase
      end
    end
  end

  task automatic issue(input bit op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Observes from the negedge after accept (cycle 0) until a response or timeout pulse.
  task automatic wait_rsp(output int cyc, output bit got_v, output bit got_t,
                          output bit busy_ok, output bit s0);
    cyc = -1; got_v = 0; got_t = 0; busy_ok = 1; s0 = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      cyc = n;
      if (n == 0) s0 = ser_out;
      if (rsp_valid) got_v = 1;
      if (rsp_timeout) got_t = 1;
      if (got_v || got_t) begin
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (ser_out !== 1'b0) begin n_fail++; $display("FAIL rst_ser_out got %b want 0", ser_out); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    n_tests++; if (rsp_result !== 20'h0) begin n_fail++; $display("FAIL rst_rsp_result got %h want 00000", rsp_result); end
    n_tests++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_timeout got %b want 0", rsp_timeout); end
    n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL rst_req_err got %b want 0", req_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset: outputs checked");
  endtask

  task automatic run_op(input string name, input bit op, input logic [15:0] a,
                        input logic [15:0] b, input logic [19:0] exp_res);
    int cyc; bit gv, gt, bok, s0;
    logic [40:0] exp_frame;
    logic [19:0] e;
    int fs;
    exp_frame = {8'hA5, op, a, b};
    fs = frames_seen;
    exp_q.push_back(exp_res);
    issue(op, a, b);
    wait_rsp(cyc, gv, gt, bok, s0);
    n_tests++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL %s first_bit got %b want 1", name, s0); end
    n_tests++; if (frames_seen != fs + 1 || last_frame !== exp_frame) begin
      n_fail++; $display("FAIL %s frame got %h want %h", name, last_frame, exp_frame); end
    n_tests++; if (!gv || gt) begin n_fail++; $display("FAIL %s rsp_valid got v=%b t=%b want v=1 t=0", name, gv, gt); end
    n_tests++; if (cyc != 73) begin n_fail++; $display("FAIL %s latency got %0d want 73", name, cyc); end
    n_tests++; if (!bok) begin n_fail++; $display("FAIL %s busy_span got broken want high accept..pulse", name); end
    if (gv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++; if (rsp_result !== e) begin n_fail++; $display("FAIL %s result got %h want %h", name, rsp_result, e); end
    end else begin
      n_tests++; n_fail++; $display("FAIL %s result got none want %h", name, exp_res);
      exp_q.delete();
    end
    $display("[TB] %s: op=%0d a=%h b=%h result=%h cycles=%0d", name, op, a, b, rsp_result, cyc);
  endtask

  task automatic test_add;
    run_op("add", 1'b0, 16'h1234, 16'h5678, 20'h06912);
  endtask

  task automatic test_sub;
    run_op("sub", 1'b1, 16'h5000, 16'h1234, 20'h03766);
  endtask

  task automatic test_carry;
    run_op("carry", 1'b0, 16'h9999, 16'h0001, 20'h10000);
  endtask

  task automatic test_timeout;
    int cyc; bit gv, gt, bok, s0;
    logic [19:0] prev;
    prev = 20'h10000;
    rsp_en = 1'b0;
    issue(1'b0, 16'h0042, 16'h0007);
    wait_rsp(cyc, gv, gt, bok, s0);
    n_tests++; if (!gt || gv) begin n_fail++; $display("FAIL timeout pulse got t=%b v=%b want t=1 v=0", gt, gv); end
    n_tests++; if (cyc != 297) begin n_fail++; $display("FAIL timeout cycle got %0d want 297 (256 after WAIT entry)", cyc); end
    n_tests++; if (rsp_result !== prev) begin n_fail++; $display("FAIL timeout result_hold got %h want %h", rsp_result, prev); end
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL timeout ready_after got %b want 1", req_ready); end
    n_tests++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout one_cycle got %b want 0", rsp_timeout); end
    rsp_en = 1'b1;
    $display("[TB] timeout: cycles=%0d", cyc);
  endtask

  task automatic test_ignore_busy;
    int cyc; bit gv, gt, bok, s0;
    bit extra;
    logic [19:0] e;
    exp_q.push_back(20'h00579);
    issue(1'b0, 16'h0123, 16'h0456);
    repeat (3) @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1; req_a = 16'h7777; req_b = 16'h1111;
    repeat (10) @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL ignore req_err got %b want 0", req_err); end
    wait_rsp(cyc, gv, gt, bok, s0);
    n_tests++; if (last_frame !== {8'hA5, 1'b0, 16'h0123, 16'h0456}) begin
      n_fail++; $display("FAIL ignore frame got %h want %h", last_frame, {8'hA5, 1'b0, 16'h0123, 16'h0456}); end
    if (gv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++; if (rsp_result !== e) begin n_fail++; $display("FAIL ignore result got %h want %h", rsp_result, e); end
    end else begin
      n_tests++; n_fail++; $display("FAIL ignore result got none want 00579");
      exp_q.delete();
    end
    extra = 0;
    repeat (60) begin @(negedge clk); if (busy) extra = 1; end
    n_tests++; if (extra) begin n_fail++; $display("FAIL ignore queued got busy=1 want 0"); end
    $display("[TB] ignore_busy: result=%h", rsp_result);
  endtask

  task automatic test_reset_abort;
    logic [40:0] f;
    bit pulse;
    f = {8'hA5, 1'b0, 16'h2468, 16'h1357};
    issue(1'b0, 16'h2468, 16'h1357);
    repeat (21) @(negedge clk);
    n_tests++; if (ser_out !== f[20]) begin n_fail++; $display("FAIL abort bit20 got %b want %b", ser_out, f[20]); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (ser_out !== 1'b0) begin n_fail++; $display("FAIL abort ser_out got %b want 0", ser_out); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort req_ready got %b want 1", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy got %b want 0", busy); end
    n_tests++; if (rsp_result !== 20'h0) begin n_fail++; $display("FAIL abort rsp_result got %h want 00000", rsp_result); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulse = 0;
    repeat (100) begin @(negedge clk); if (rsp_valid || rsp_timeout || busy) pulse = 1; end
    n_tests++; if (pulse) begin n_fail++; $display("FAIL abort pulses got activity want none"); end
    $display("[TB] reset_abort: checked");
    run_op("after_abort", 1'b0, 16'h0250, 16'h0750, 20'h01000);
  endtask

  task automatic test_bcd_check;
`ifdef BCD_CHECK_EN
    bit leak;
    issue(1'b0, 16'h12A4, 16'h0001);
    @(negedge clk);
    n_tests++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL bcd req_err got %b want 1", req_err); end
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bcd req_ready got %b want 0", req_ready); end
    @(negedge clk);
    n_tests++; if (req_err !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bcd recover got err=%b ready=%b want err=0 ready=1", req_err, req_ready); end
    leak = 0;
    repeat (60) begin @(negedge clk); if (ser_out || busy) leak = 1; end
    n_tests++; if (leak) begin n_fail++; $display("FAIL bcd no_send got activity want idle"); end
    $display("[TB] bcd_check: rejected a=12A4");
`else
    int cyc; bit gv, gt, bok, s0;
    bit err_seen;
    int fs;
    fs = frames_seen;
    issue(1'b0, 16'h12A4, 16'h0001);
    err_seen = (req_err === 1'b1);
    wait_rsp(cyc, gv, gt, bok, s0);
    n_tests++; if (frames_seen != fs + 1 || last_frame !== {8'hA5, 1'b0, 16'h12A4, 16'h0001}) begin
      n_fail++; $display("FAIL bcd frame got %h want %h", last_frame, {8'hA5, 1'b0, 16'h12A4, 16'h0001}); end
    n_tests++; if (!gv) begin n_fail++; $display("FAIL bcd rsp_valid got 0 want 1"); end
    n_tests++; if (err_seen || bok == 0) begin n_fail++; $display("FAIL bcd req_err_or_busy got err=%b busy_ok=%b want 0/1", err_seen, bok); end
    $display("[TB] bcd_check: unchecked frame sent, cycles=%0d", cyc);
`endif
  endtask

  initial begin : main
    test_reset();
    test_add();
    test_sub();
    test_carry();
    test_timeout();
    test_ignore_busy();
    test_reset_abort();
    test_bcd_check();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
